// File: rtl/ex_pkg.sv
// Shared decode constants, scoreboard state encoding and ALU op set for the execute stage.
// Aging helper keeps the EX -> MEM -> WB -> IDLE progression in one place.
package ex_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        SB_IDLE   = 3'd0,
        SB_EX_ALU = 3'd1,
        SB_EX_LD  = 3'd2,
        SB_MEM    = 3'd3,
        SB_WB     = 3'd4
    } sb_state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    function automatic sb_state_t sb_age(input sb_state_t s);
        case (s)
            SB_EX_ALU, SB_EX_LD: return SB_MEM;
            SB_MEM:              return SB_WB;
            default:             return SB_IDLE;
        endcase
    endfunction
endpackage

// File: rtl/ex_scoreboard.sv
// Per-register pipeline-position tracker for in-flight writes; lookups are combinational.
// Latency: set/age take effect on the next edge.
// Backpressure: hold freezes every entry.
module ex_scoreboard
    import ex_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              hold,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_reg,
    input  logic              set_load,
    input  logic [REG_AW-1:0] rs_idx,
    input  logic [REG_AW-1:0] rt_idx,
    output sb_state_t         rs_state,
    output sb_state_t         rt_state
);
    localparam int N = 2**REG_AW;

    sb_state_t sb [N];

    // The issuing instruction is the youngest writer, so it overrides the aged value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) sb[i] <= SB_IDLE;
        end else if (!hold) begin
            for (int i = 0; i < N; i++) begin
                if (set_en && set_reg == REG_AW'(i))
                    sb[i] <= set_load ? SB_EX_LD : SB_EX_ALU;
                else
                    sb[i] <= sb_age(sb[i]);
            end
        end
    end

    assign rs_state = (rs_idx == '0) ? SB_IDLE : sb[rs_idx];
    assign rt_state = (rt_idx == '0) ? SB_IDLE : sb[rt_idx];
endmodule

// File: rtl/ex_stage_sb.sv
// MIPS execute stage: decode, forward, ALU/address arithmetic, EX/MEM latch.
// Latency: 1 cycle from ID/EX to ex_* outputs.
// Backpressure: hold freezes everything; load-use (or any pending source without forwarding) stalls ID.
module ex_stage_sb
    import ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int MEM_AW = 10,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       ir,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic [DATA_W-1:0] imm,
    input  logic              hold,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_result,
    output logic              stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_result,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [MEM_AW-1:0] ex_mem_addr,
    output logic [REG_AW-1:0] ex_wb_reg,
    output logic              ex_is_load,
    output logic              ex_illegal
);
    logic [5:0]        opcode, funct;
    logic [REG_AW-1:0] rs_idx, rt_idx, rd_idx, dest;
    logic              legal, is_load, is_store, uses_rs, uses_rt, use_imm;
    alu_op_t           alu_op;
    sb_state_t         rs_state, rt_state;
    logic [DATA_W-1:0] rs_op, rt_op, op_b, alu_res;
    logic              issue;
    logic              unused_shamt;

    assign opcode       = ir[31:26];
    assign funct        = ir[5:0];
    assign rs_idx       = REG_AW'(ir[25:21]);
    assign rt_idx       = REG_AW'(ir[20:16]);
    assign rd_idx       = REG_AW'(ir[15:11]);
    assign unused_shamt = ^ir[10:6];

    always_comb begin
        legal    = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        uses_rs  = 1'b0;
        uses_rt  = 1'b0;
        use_imm  = 1'b0;
        alu_op   = ALU_ADD;
        dest     = '0;
        case (opcode)
            OP_RTYPE: begin
                legal   = 1'b1;
                uses_rs = 1'b1;
                uses_rt = 1'b1;
                dest    = rd_idx;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: begin
                        legal   = 1'b0;
                        uses_rs = 1'b0;
                        uses_rt = 1'b0;
                        dest    = '0;
                    end
                endcase
            end
            OP_ADDI: begin
                legal = 1'b1; uses_rs = 1'b1; use_imm = 1'b1; dest = rt_idx;
            end
            OP_LW: begin
                legal = 1'b1; uses_rs = 1'b1; use_imm = 1'b1; is_load = 1'b1; dest = rt_idx;
            end
            OP_SW: begin
                legal = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; use_imm = 1'b1; is_store = 1'b1;
            end
            default: ;
        endcase
    end

    function automatic logic src_hazard(input sb_state_t st);
        return FWD_EN ? (st == SB_EX_LD) : (st != SB_IDLE);
    endfunction

    assign stall = in_valid && !hold &&
                   ((uses_rs && src_hazard(rs_state)) || (uses_rt && src_hazard(rt_state)));
    assign issue = in_valid && !stall;

    // EX_ALU means the producer sits in our own EX/MEM latch right now.
    always_comb begin
        rs_op = rs_val;
        case (rs_state)
            SB_EX_ALU: rs_op = ex_result;
            SB_MEM:    rs_op = mem_result;
            SB_WB:     rs_op = wb_result;
            default:   rs_op = rs_val;
        endcase
        rt_op = rt_val;
        case (rt_state)
            SB_EX_ALU: rt_op = ex_result;
            SB_MEM:    rt_op = mem_result;
            SB_WB:     rt_op = wb_result;
            default:   rt_op = rt_val;
        endcase
    end

    assign op_b = use_imm ? imm : rt_op;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD: alu_res = rs_op + op_b;
            ALU_SUB: alu_res = rs_op - op_b;
            ALU_AND: alu_res = rs_op & op_b;
            ALU_OR:  alu_res = rs_op | op_b;
            ALU_SLT: alu_res = DATA_W'($signed(rs_op) < $signed(op_b));
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_result     <= '0;
            ex_store_data <= '0;
            ex_mem_addr   <= '0;
            ex_wb_reg     <= '0;
            ex_is_load    <= 1'b0;
            ex_illegal    <= 1'b0;
        end else if (!hold) begin
            ex_valid      <= issue;
            ex_result     <= (issue && legal) ? alu_res : '0;
            ex_store_data <= (issue && is_store) ? rt_op : '0;
            ex_mem_addr   <= (issue && (is_load || is_store)) ? alu_res[MEM_AW-1:0] : '0;
            ex_wb_reg     <= issue ? dest : '0;
            ex_is_load    <= issue && is_load;
            ex_illegal    <= issue && !legal;
        end
    end

    ex_scoreboard #(.REG_AW(REG_AW)) u_sb (
        .clock    (clock),
        .reset    (reset),
        .hold     (hold),
        .set_en   (issue && legal && (dest != '0)),
        .set_reg  (dest),
        .set_load (is_load),
        .rs_idx   (rs_idx),
        .rt_idx   (rt_idx),
        .rs_state (rs_state),
        .rt_state (rt_state)
    );
endmodule

// File: tb/tb_ex_stage_sb.sv
// Directed bench for ex_stage_sb: forwarding, load-use stall, hold, reset, wrap and a no-forwarding build.
// Both DUT copies share stimulus; the FWD_EN=0 copy is only checked in its own section after a reset.
module tb_ex_stage_sb;
    import ex_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, hold = 1'b0;
    logic [31:0] ir = '0, rs_val = '0, rt_val = '0, imm = '0, mem_result = '0, wb_result = '0;

    logic        stall, ex_valid, ex_is_load, ex_illegal;
    logic [31:0] ex_result, ex_store_data;
    logic [9:0]  ex_mem_addr;
    logic [4:0]  ex_wb_reg;

    logic        stall_nf, ex_valid_nf, ex_is_load_nf, ex_illegal_nf;
    logic [31:0] ex_result_nf, ex_store_data_nf;
    logic [9:0]  ex_mem_addr_nf;
    logic [4:0]  ex_wb_reg_nf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    ex_stage_sb dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .ir(ir),
        .rs_val(rs_val), .rt_val(rt_val), .imm(imm), .hold(hold),
        .mem_result(mem_result), .wb_result(wb_result), .stall(stall),
        .ex_valid(ex_valid), .ex_result(ex_result), .ex_store_data(ex_store_data),
        .ex_mem_addr(ex_mem_addr), .ex_wb_reg(ex_wb_reg),
        .ex_is_load(ex_is_load), .ex_illegal(ex_illegal)
    );

    ex_stage_sb #(.FWD_EN(1'b0)) dut_nf (
        .clock(clock), .reset(reset), .in_valid(in_valid), .ir(ir),
        .rs_val(rs_val), .rt_val(rt_val), .imm(imm), .hold(hold),
        .mem_result(mem_result), .wb_result(wb_result), .stall(stall_nf),
        .ex_valid(ex_valid_nf), .ex_result(ex_result_nf), .ex_store_data(ex_store_data_nf),
        .ex_mem_addr(ex_mem_addr_nf), .ex_wb_reg(ex_wb_reg_nf),
        .ex_is_load(ex_is_load_nf), .ex_illegal(ex_illegal_nf)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rs, input int rt, input int rd);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] im);
        return {op, 5'(rs), 5'(rt), im};
    endfunction

    task automatic put(input logic v, input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        ir       = w;
        rs_val   = a;
        rt_val   = b;
        imm      = {{16{w[15]}}, w[15:0]};
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } alu_vec_t;

    alu_vec_t vecs [6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        vecs = '{'{FN_AND, 32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234},
                 '{FN_OR,  32'hF0000000, 32'h0000000F, 32'hF000000F},
                 '{FN_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001},
                 '{FN_SLT, 32'h00000005, 32'hFFFFFFFD, 32'h00000000},
                 '{FN_SUB, 32'h00000003, 32'h00000005, 32'hFFFFFFFE},
                 '{FN_ADD, 32'hFFFFFFFF, 32'h00000002, 32'h00000001}};

        // reset state
        tick(); tick();
        chk("rst_valid", ex_valid, 0);
        chk("rst_result", ex_result, 0);
        chk("rst_wb_reg", ex_wb_reg, 0);
        chk("rst_stall", stall, 0);
        reset = 1'b0;

        // EX forward back-to-back
        put(1, enc_i(OP_ADDI, 0, 1, 16'd5), 0, 0);
        #1 chk("addi_stall", stall, 0);
        tick();
        chk("addi_valid", ex_valid, 1);
        chk("addi_result", ex_result, 5);
        chk("addi_wb_reg", ex_wb_reg, 1);
        put(1, enc_r(FN_ADD, 1, 1, 2), 0, 0);
        #1 chk("exfwd_stall", stall, 0);
        tick();
        chk("exfwd_result", ex_result, 10);
        chk("exfwd_wb_reg", ex_wb_reg, 2);

        // reset while a load is pending and a dependent stalls
        put(1, enc_i(OP_LW, 0, 4, 16'd0), 0, 0);
        tick();
        chk("rlw_is_load", ex_is_load, 1);
        put(1, enc_i(OP_ADDI, 4, 5, 16'd1), 0, 0);
        #1 chk("rlw_stall", stall, 1);
        #2 reset = 1'b1;
        #1;
        chk("rmid_stall", stall, 0);
        chk("rmid_valid", ex_valid, 0);
        chk("rmid_wb_reg", ex_wb_reg, 0);
        chk("rmid_is_load", ex_is_load, 0);
        tick();
        reset = 1'b0;
        put(1, enc_i(OP_ADDI, 0, 1, 16'd5), 0, 0);
        #1 chk("post_rst_stall", stall, 0);
        tick();
        chk("post_rst_result", ex_result, 5);

        // WB forward after two bubbles
        put(1, enc_i(OP_ADDI, 0, 1, 16'd7), 0, 0);
        tick();
        put(0, 32'h0, 0, 0);
        tick();
        chk("nop_valid", ex_valid, 0);
        tick();
        mem_result = 32'h55;
        wb_result  = 32'h7;
        put(1, enc_r(FN_SUB, 1, 0, 3), 0, 0);
        #1 chk("wbfwd_stall", stall, 0);
        tick();
        chk("wbfwd_result", ex_result, 7);
        chk("wbfwd_wb_reg", ex_wb_reg, 3);

        // load-use: one stall cycle, then MEM forward
        put(1, enc_i(OP_LW, 0, 4, 16'd0), 0, 0);
        tick();
        chk("lw_is_load", ex_is_load, 1);
        chk("lw_addr", ex_mem_addr, 0);
        chk("lw_wb_reg", ex_wb_reg, 4);
        put(1, enc_i(OP_ADDI, 4, 5, 16'd1), 0, 0);
        #1 chk("lu_stall", stall, 1);
        tick();
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_bubble_wb_reg", ex_wb_reg, 0);
        mem_result = 32'd9;
        #1 chk("lu_release", stall, 0);
        tick();
        chk("lu_result", ex_result, 10);
        chk("lu_wb_reg", ex_wb_reg, 5);

        // sw with address wrap into MEM_AW bits
        put(1, enc_i(OP_SW, 2, 1, 16'd3), 32'h3FE, 32'hAA);
        #1 chk("sw_stall", stall, 0);
        tick();
        chk("sw_addr", ex_mem_addr, 10'h001);
        chk("sw_data", ex_store_data, 32'hAA);
        chk("sw_wb_reg", ex_wb_reg, 0);
        chk("sw_result", ex_result, 32'h401);
        chk("sw_valid", ex_valid, 1);

        // ALU ops from idle registers
        foreach (vecs[i]) begin
            put(1, enc_r(vecs[i].fn, 10, 11, 12), vecs[i].a, vecs[i].b);
            tick();
            chk($sformatf("alu%0d_result", i), ex_result, vecs[i].r);
            chk($sformatf("alu%0d_illegal", i), ex_illegal, 0);
        end

        // illegal opcode and illegal funct
        put(1, {6'b000010, 26'h0}, 0, 0);
        tick();
        chk("ill_op_valid", ex_valid, 1);
        chk("ill_op_flag", ex_illegal, 1);
        chk("ill_op_wb_reg", ex_wb_reg, 0);
        put(1, enc_r(6'b100111, 10, 11, 12), 0, 0);
        tick();
        chk("ill_fn_flag", ex_illegal, 1);
        chk("ill_fn_wb_reg", ex_wb_reg, 0);

        // hold freezes outputs and scoreboard
        mem_result = 32'h55;
        wb_result  = 32'h66;
        put(1, enc_i(OP_ADDI, 0, 1, 16'd5), 0, 0);
        tick();
        hold = 1'b1;
        put(1, enc_r(FN_ADD, 1, 1, 2), 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1 chk("hold_stall", stall, 0);
            tick();
            chk("hold_result", ex_result, 5);
            chk("hold_wb_reg", ex_wb_reg, 1);
        end
        hold = 1'b0;
        tick();
        chk("hold_after_result", ex_result, 10);

        // hold wins over a load-use stall
        put(1, enc_i(OP_LW, 0, 4, 16'd0), 0, 0);
        tick();
        hold = 1'b1;
        put(1, enc_i(OP_ADDI, 4, 5, 16'd1), 0, 0);
        #1 chk("hs_stall_held", stall, 0);
        tick();
        chk("hs_is_load_frozen", ex_is_load, 1);
        hold = 1'b0;
        #1 chk("hs_stall_after", stall, 1);
        tick();
        chk("hs_bubble", ex_valid, 0);
        put(0, 32'h0, 0, 0);
        tick();

        // no-forwarding build: dependent add waits for three stages to drain
        reset = 1'b1;
        #2 reset = 1'b0;
        chk("nf_rst_valid", ex_valid_nf, 0);
        put(1, enc_i(OP_ADDI, 0, 1, 16'd5), 0, 0);
        #1 chk("nf_addi_stall", stall_nf, 0);
        tick();
        chk("nf_addi_result", ex_result_nf, 5);
        put(1, enc_r(FN_ADD, 1, 1, 2), 5, 5);
        #1;
        cnt = 0;
        while (stall_nf && cnt < 10) begin
            tick();
            cnt++;
            chk("nf_bubble", ex_valid_nf, 0);
        end
        chk("nf_stall_cycles", cnt, 3);
        tick();
        chk("nf_add_result", ex_result_nf, 10);
        chk("nf_add_wb_reg", ex_wb_reg_nf, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
